// File: rtl/hlsm_pkg.sv
// hlsm_pkg
//   Shared types and constants for the HLSM job controller.
//   - state_t   : controller FSM state encoding
//   - W_DEF     : default operand/result width
//   - N_FIELDS  : operand fields per job ({a,b,c,d,e,f})
//   - OFF_*     : LSB offset of each field in in_ops for the default width
//   - field_lsb : LSB offset of field idx (0 = a) for an arbitrary width
package hlsm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    RESULT = 2'd3
  } state_t;

  localparam int W_DEF       = 16;
  localparam int LAT_MAX_DEF = 15;
  localparam int N_FIELDS    = 6;

  // a sits in the MSBs, f in the LSBs
  localparam int OFF_A = 5 * W_DEF;
  localparam int OFF_B = 4 * W_DEF;
  localparam int OFF_C = 3 * W_DEF;
  localparam int OFF_D = 2 * W_DEF;
  localparam int OFF_E = 1 * W_DEF;
  localparam int OFF_F = 0;

  function automatic int field_lsb(input int idx, input int w);
    return (N_FIELDS - 1 - idx) * w;
  endfunction

endpackage

// File: rtl/hlsm_job_ctrl_if.sv
// hlsm_job_ctrl_if
//   Groups the operand stream, the HLSM launch/complete handshake and the
//   result stream of the job controller.
//   Modports:
//     slave  : controller side (hlsm_job_ctrl)
//     master : environment side (operand producer, HLSM, result consumer)
//   Signals:
//     in_valid/in_ready/in_ops   operand set stream, in_ops = {a,b,c,d,e,f}
//     Start/hlsm_ops             launch pulse and held operands to the HLSM
//     Done/j_in/k_in             HLSM completion and results
//     out_valid/out_ready/out_j/out_k  result stream
interface hlsm_job_ctrl_if
  import hlsm_pkg::*;
#(
  parameter int W = W_DEF
);

  logic                  in_valid;
  logic                  in_ready;
  logic [N_FIELDS*W-1:0] in_ops;
  logic                  Start;
  logic [N_FIELDS*W-1:0] hlsm_ops;
  logic                  Done;
  logic [W-1:0]          j_in;
  logic [W-1:0]          k_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [W-1:0]          out_j;
  logic [W-1:0]          out_k;

  modport slave (
    input  in_valid, in_ops, Done, j_in, k_in, out_ready,
    output in_ready, Start, hlsm_ops, out_valid, out_j, out_k
  );

  modport master (
    output in_valid, in_ops, Done, j_in, k_in, out_ready,
    input  in_ready, Start, hlsm_ops, out_valid, out_j, out_k
  );

endinterface

// File: rtl/hlsm_job_ctrl.sv
// hlsm_job_ctrl
//   Control stage around the scheduled HLSM datapath. Accepts an operand set,
//   holds it for the HLSM, issues a one-cycle Start, waits for Done, captures
//   j/k and offers them on the result stream. Counts completed jobs.
//   Ports:
//     Clk      clock
//     Rst      asynchronous active-low reset
//     bus      hlsm_job_ctrl_if.slave (operand stream, HLSM handshake,
//              result stream)
//     job_cnt  completed jobs, wraps 255 -> 0
//     err      (HLSM_JOB_WDOG_EN only) sticky watchdog timeout flag
//   Optional feature macro: HLSM_JOB_WDOG_EN adds a Start-to-Done watchdog
//   (LAT_MAX cycles) that abandons a hung job and raises err.
//
//   state  | meaning
//   IDLE   | ready for an operand set; capture on in_valid
//   LAUNCH | Start high for this single cycle
//   BUSY   | waiting for Done from the HLSM
//   RESULT | out_valid high, waiting for out_ready
module hlsm_job_ctrl
  import hlsm_pkg::*;
#(
  parameter int W = W_DEF
`ifdef HLSM_JOB_WDOG_EN
  , parameter int LAT_MAX = LAT_MAX_DEF
`endif
) (
  input  logic                  Clk,
  input  logic                  Rst,
  hlsm_job_ctrl_if.slave        bus,
  output logic [7:0]            job_cnt
`ifdef HLSM_JOB_WDOG_EN
  , output logic                err
`endif
);

  state_t state, state_nxt;
  logic   cap_ops;
  logic   cap_res;

`ifdef HLSM_JOB_WDOG_EN
  localparam int CW = $clog2(LAT_MAX + 1);
  logic [CW-1:0] wdog_cnt;
  logic          wdog_exp;
  logic          wdog_trip;

  assign wdog_exp = (wdog_cnt == '0);
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Done is only looked at in BUSY; the HLSM does not reset it, so any
  // value seen in other states is meaningless.
  always_comb begin
    state_nxt     = state;
    cap_ops       = 1'b0;
    cap_res       = 1'b0;
    bus.in_ready  = 1'b0;
    bus.Start     = 1'b0;
    bus.out_valid = 1'b0;
`ifdef HLSM_JOB_WDOG_EN
    wdog_trip     = 1'b0;
`endif
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          cap_ops   = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        bus.Start = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        if (bus.Done) begin
          cap_res   = 1'b1;
          state_nxt = RESULT;
        end
`ifdef HLSM_JOB_WDOG_EN
        else if (wdog_exp) begin
          wdog_trip = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      RESULT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands stay put from capture until the next capture, so the HLSM can
  // read any field in any of its states.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)         bus.hlsm_ops <= '0;
    else if (cap_ops) bus.hlsm_ops <= bus.in_ops;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      bus.out_j <= '0;
      bus.out_k <= '0;
      job_cnt   <= '0;
    end else if (cap_res) begin
      bus.out_j <= bus.j_in;
      bus.out_k <= bus.k_in;
      job_cnt   <= job_cnt + 8'd1;
    end
  end

`ifdef HLSM_JOB_WDOG_EN
  // Loaded in LAUNCH; BUSY may run LAT_MAX+1 cycles before the trip.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wdog_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state == LAUNCH)                wdog_cnt <= CW'(LAT_MAX);
      else if (state == BUSY && !wdog_exp) wdog_cnt <= wdog_cnt - 1'b1;
      if (wdog_trip) err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hlsm_job_ctrl.sv
module tb_hlsm_job_ctrl;
  import hlsm_pkg::*;

  localparam int W  = W_DEF;
  localparam int OW = N_FIELDS * W;

  logic       Clk;
  logic       Rst;
  logic [7:0] job_cnt;
`ifdef HLSM_JOB_WDOG_EN
  logic       err;
`endif

  hlsm_job_ctrl_if #(.W(W)) bus ();

  hlsm_job_ctrl #(.W(W)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .bus     (bus),
    .job_cnt (job_cnt)
`ifdef HLSM_JOB_WDOG_EN
    , .err   (err)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_cnt = 8'd0;

  typedef struct {
    logic [OW-1:0] ops;
    logic [W-1:0]  j;
    logic [W-1:0]  k;
    int            hold;
    bit            done_in_launch;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [OW-1:0] act,
                     input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] pack(input int a, input int b, input int c,
                                         input int d, input int e, input int f);
    return {W'(a), W'(b), W'(c), W'(d), W'(e), W'(f)};
  endfunction

  // Entered at a negedge with the controller in IDLE; returns at the negedge
  // of the first IDLE cycle after the result handshake. The HLSM is modelled
  // as raising Done in cycle 9 (accept = cycle 0). With hold>0, out_ready is
  // low for hold RESULT cycles while next_ops is offered on in_valid.
  task automatic do_job(input logic [OW-1:0] ops, input logic [W-1:0] j,
                        input logic [W-1:0] k, input int hold,
                        input bit done_in_launch, input logic [OW-1:0] next_ops);
    chk("idle_in_ready", OW'(bus.in_ready), OW'(1));
    bus.in_valid = 1'b1;
    bus.in_ops   = ops;
    @(negedge Clk);
    bus.in_valid = 1'b0;
    bus.in_ops   = ~ops;
    chk("launch_start", OW'(bus.Start), OW'(1));
    chk("launch_hlsm_ops", bus.hlsm_ops, ops);
    chk("launch_in_ready", OW'(bus.in_ready), OW'(0));
    if (done_in_launch) begin
      bus.Done = 1'b1;
      bus.j_in = ~j;
      bus.k_in = ~k;
    end
    for (int c = 2; c <= 9; c++) begin
      @(negedge Clk);
      bus.Done = (c == 9);
      bus.j_in = (c == 9) ? j : W'(c * 37);
      bus.k_in = (c == 9) ? k : W'(c * 91);
      chk("busy_start", OW'(bus.Start), OW'(0));
      chk("busy_out_valid", OW'(bus.out_valid), OW'(0));
      chk("busy_hlsm_ops", bus.hlsm_ops, ops);
    end
    @(negedge Clk);
    bus.Done = 1'b0;
    bus.j_in = '0;
    bus.k_in = '0;
    exp_cnt++;
    chk("res_out_valid", OW'(bus.out_valid), OW'(1));
    chk("res_out_j", OW'(bus.out_j), OW'(j));
    chk("res_out_k", OW'(bus.out_k), OW'(k));
    chk("res_job_cnt", OW'(job_cnt), OW'(exp_cnt));
    if (hold > 0) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_ops    = next_ops;
      for (int h = 1; h <= hold; h++) begin
        @(negedge Clk);
        chk("hold_out_valid", OW'(bus.out_valid), OW'(1));
        chk("hold_out_j", OW'(bus.out_j), OW'(j));
        chk("hold_out_k", OW'(bus.out_k), OW'(k));
        chk("hold_in_ready", OW'(bus.in_ready), OW'(0));
        chk("hold_start", OW'(bus.Start), OW'(0));
        chk("hold_hlsm_ops", bus.hlsm_ops, ops);
      end
      bus.out_ready = 1'b1;
    end
    @(negedge Clk);
    chk("post_out_valid", OW'(bus.out_valid), OW'(0));
    chk("post_in_ready", OW'(bus.in_ready), OW'(1));
    chk("post_start", OW'(bus.Start), OW'(0));
  endtask

  initial begin
    vecs[0] = '{pack(2, 3, 4, 5, 6, 7), W'(50), W'(42), 0, 1'b0};
    vecs[1] = '{pack(-3, 4, 2, -1, -5, 5), W'(10), W'(-25), 0, 1'b1};
    vecs[2] = '{pack(100, -200, 300, -400, 500, -600), 16'h7fff, 16'h8000, 20, 1'b0};
    vecs[3] = '{pack(-1, 1, -32768, 32767, 0, 9), 16'hffff, 16'h0000, 0, 1'b0};

    Rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_ops    = '0;
    bus.Done      = 1'b0;
    bus.j_in      = '0;
    bus.k_in      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_in_ready", OW'(bus.in_ready), OW'(1));
    chk("rst_start", OW'(bus.Start), OW'(0));
    chk("rst_out_valid", OW'(bus.out_valid), OW'(0));
    chk("rst_job_cnt", OW'(job_cnt), OW'(0));
    chk("rst_hlsm_ops", bus.hlsm_ops, OW'(0));
`ifdef HLSM_JOB_WDOG_EN
    chk("rst_err", OW'(err), OW'(0));
`endif
    Rst = 1'b1;
    @(negedge Clk);

    // vecs[2] holds the result and offers vecs[3] meanwhile; vecs[3] is then
    // accepted in the first IDLE cycle after the handshake.
    for (int i = 0; i < 4; i++)
      do_job(vecs[i].ops, vecs[i].j, vecs[i].k, vecs[i].hold,
             vecs[i].done_in_launch, (i < 3) ? vecs[i+1].ops : '0);

    // Reset in the middle of BUSY
    bus.in_valid = 1'b1;
    bus.in_ops   = vecs[0].ops;
    @(negedge Clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("mid_rst_start", OW'(bus.Start), OW'(0));
    chk("mid_rst_out_valid", OW'(bus.out_valid), OW'(0));
    chk("mid_rst_hlsm_ops", bus.hlsm_ops, OW'(0));
    chk("mid_rst_out_j", OW'(bus.out_j), OW'(0));
    chk("mid_rst_out_k", OW'(bus.out_k), OW'(0));
    chk("mid_rst_job_cnt", OW'(job_cnt), OW'(0));
    chk("mid_rst_in_ready", OW'(bus.in_ready), OW'(1));
    @(negedge Clk);
    Rst      = 1'b1;
    exp_cnt  = 8'd0;
    bus.Done = 1'b1;
    bus.j_in = W'(123);
    bus.k_in = W'(456);
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      chk("late_done_out_valid", OW'(bus.out_valid), OW'(0));
      chk("late_done_job_cnt", OW'(job_cnt), OW'(0));
      chk("late_done_in_ready", OW'(bus.in_ready), OW'(1));
    end
    bus.Done = 1'b0;

    // job_cnt wrap: 256 jobs bring it through 255 back to 0
    for (int n = 0; n < 256; n++)
      do_job(pack(n, -n, n + 1, 2 * n, -7, n ^ 5), W'(n * 3), W'(-n), 0, 1'b0, '0);
    chk("wrap_job_cnt", OW'(job_cnt), OW'(0));

`ifdef HLSM_JOB_WDOG_EN
    // Done tied low: BUSY runs LAT_MAX+1 cycles, then err and back to IDLE
    bus.in_valid = 1'b1;
    bus.in_ops   = vecs[1].ops;
    @(negedge Clk);
    bus.in_valid = 1'b0;
    chk("wd_start", OW'(bus.Start), OW'(1));
    for (int c = 0; c < LAT_MAX_DEF + 1; c++) begin
      @(negedge Clk);
      chk("wd_busy_err", OW'(err), OW'(0));
      chk("wd_busy_in_ready", OW'(bus.in_ready), OW'(0));
      chk("wd_busy_out_valid", OW'(bus.out_valid), OW'(0));
    end
    @(negedge Clk);
    chk("wd_err", OW'(err), OW'(1));
    chk("wd_in_ready", OW'(bus.in_ready), OW'(1));
    chk("wd_out_valid", OW'(bus.out_valid), OW'(0));
    chk("wd_job_cnt", OW'(job_cnt), OW'(exp_cnt));
    repeat (5) @(negedge Clk);
    chk("wd_err_sticky", OW'(err), OW'(1));
    chk("wd_out_valid_late", OW'(bus.out_valid), OW'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
